// File: rtl/conveyor_pkg.sv
// Shared types and width helpers for the multi-context result conveyor.
package conveyor_pkg;

  typedef enum logic [1:0] {
    FREE    = 2'b00,
    PENDING = 2'b01,
    DONE    = 2'b10
  } slot_state_t;

  function automatic int unsigned word_width(input int unsigned word_mag);
    return 1 << word_mag;
  endfunction

  function automatic int unsigned depth(input int unsigned depth_mag);
    return 1 << depth_mag;
  endfunction

  // A single context still needs a one-bit selector.
  function automatic int unsigned ctx_width(input int unsigned contexts);
    return (contexts > 1) ? $clog2(contexts) : 1;
  endfunction

endpackage

// File: rtl/conveyor_if.sv
// Conveyor bus: allocation, completion writes, read/consume, flush and status.
interface conveyor_if import conveyor_pkg::*; #(
  parameter int unsigned WORD_MAG    = 5,
  parameter int unsigned DEPTH_MAG   = 4,
  parameter int unsigned CONTEXTS    = 2,
  parameter int unsigned WRITE_PORTS = 2
) ();
  localparam int unsigned WORD_WIDTH = word_width(WORD_MAG);
  localparam int unsigned CTX_W      = ctx_width(CONTEXTS);

  logic                                     alloc;
  logic [CTX_W-1:0]                         alloc_ctx;
  logic                                     alloc_ready;
  logic [DEPTH_MAG-1:0]                     alloc_slot;
  logic [WRITE_PORTS-1:0]                   wr_valid;
  logic [WRITE_PORTS-1:0][CTX_W-1:0]        wr_ctx;
  logic [WRITE_PORTS-1:0][DEPTH_MAG-1:0]    wr_slot;
  logic [WRITE_PORTS-1:0][WORD_WIDTH-1:0]   wr_data;
  logic [CTX_W-1:0]                         rd_ctx;
  logic [DEPTH_MAG-1:0]                     rd_offset;
  logic [WORD_WIDTH-1:0]                    rd_data;
  logic                                     rd_finished;
  logic                                     rd_consume;
  logic [CONTEXTS-1:0]                      flush;
  logic [CONTEXTS-1:0][DEPTH_MAG:0]         occupancy;
  logic                                     error;

  modport master (
    output alloc, alloc_ctx, wr_valid, wr_ctx, wr_slot, wr_data,
    output rd_ctx, rd_offset, rd_consume, flush,
    input  alloc_ready, alloc_slot, rd_data, rd_finished, occupancy, error
  );

  modport slave (
    input  alloc, alloc_ctx, wr_valid, wr_ctx, wr_slot, wr_data,
    input  rd_ctx, rd_offset, rd_consume, flush,
    output alloc_ready, alloc_slot, rd_data, rd_finished, occupancy, error
  );

endinterface

// File: rtl/conveyor_context.sv
// One conveyor context: slot states and data, decrementing head, occupancy and error pulse.
module conveyor_context import conveyor_pkg::*; #(
  parameter int unsigned WORD_WIDTH  = 32,
  parameter int unsigned DEPTH_MAG   = 4,
  parameter int unsigned WRITE_PORTS = 2
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           flush,
  input  logic                                           alloc,
  input  logic [WRITE_PORTS-1:0]                         wr_en,
  input  logic [WRITE_PORTS-1:0][DEPTH_MAG-1:0]          wr_slot,
  input  logic [WRITE_PORTS-1:0][WORD_WIDTH-1:0]         wr_data,
  input  logic                                           consume,
  input  logic                                           consume_fwd,
  input  logic [DEPTH_MAG-1:0]                           consume_slot,
  output logic [DEPTH_MAG-1:0]                           head,
  output logic [depth(DEPTH_MAG)-1:0][1:0]               states,
  output logic [depth(DEPTH_MAG)-1:0][WORD_WIDTH-1:0]    data,
  output logic [DEPTH_MAG:0]                             occupancy,
  output logic                                           err
);
  localparam int unsigned DEPTH = depth(DEPTH_MAG);

  typedef struct packed {
    slot_state_t           state;
    logic [WORD_WIDTH-1:0] data;
  } slot_t;

  slot_t [DEPTH-1:0]    slot_q, slot_d;
  logic [DEPTH_MAG-1:0] head_q, head_d;
  logic [DEPTH_MAG:0]   occ_q, occ_d;
  logic [WRITE_PORTS-1:0] wr_win;
  logic                 err_d;

  always_comb begin
    slot_d = slot_q;
    head_d = head_q;
    wr_win = '0;
    err_d  = 1'b0;
    occ_d  = '0;
    if (flush) begin
      head_d = '0;
      for (int i = 0; i < DEPTH; i++) slot_d[i].state = FREE;
    end else begin
      if (alloc) begin
        head_d = head_q - DEPTH_MAG'(1);
        slot_d[head_d].state = PENDING;
      end
      // Lowest-index port wins a same-slot collision.
      for (int p = 0; p < WRITE_PORTS; p++) begin
        wr_win[p] = wr_en[p];
        for (int q = 0; q < p; q++) begin
          if (wr_en[p] && wr_en[q] && wr_slot[q] == wr_slot[p]) begin
            wr_win[p] = 1'b0;
            err_d     = 1'b1;
          end
        end
      end
      for (int p = 0; p < WRITE_PORTS; p++) begin
        if (wr_win[p]) begin
          case (slot_q[wr_slot[p]].state)
            PENDING: begin
              slot_d[wr_slot[p]].state = DONE;
              slot_d[wr_slot[p]].data  = wr_data[p];
            end
            DONE:    err_d = 1'b1;
            default: ;
          endcase
        end
      end
      // A forwarded consume retires the slot its own write is filling this cycle.
      if (consume) begin
        if (slot_q[consume_slot].state == DONE || consume_fwd) begin
          slot_d[consume_slot].state = FREE;
        end else begin
          err_d = 1'b1;
        end
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_d[i].state != FREE) occ_d = occ_d + (DEPTH_MAG + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q <= '0;
      head_q <= '0;
      occ_q  <= '0;
    end else begin
      slot_q <= slot_d;
      head_q <= head_d;
      occ_q  <= occ_d;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      states[i] = slot_q[i].state;
      data[i]   = slot_q[i].data;
    end
  end

  assign head      = head_q;
  assign occupancy = occ_q;
  assign err       = err_d;

endmodule

// File: rtl/conveyor_file.sv
// Multi-context result conveyor top: decode, read mux, sticky error.
// Define CONVEYOR_FORWARD_EN to bypass a same-cycle write onto the read port.
module conveyor_file import conveyor_pkg::*; #(
  parameter int unsigned WORD_MAG    = 5,
  parameter int unsigned DEPTH_MAG   = 4,
  parameter int unsigned CONTEXTS    = 2,
  parameter int unsigned WRITE_PORTS = 2
) (
  input logic       clk,
  input logic       reset,
  conveyor_if.slave bus
);
  localparam int unsigned WORD_WIDTH = word_width(WORD_MAG);
  localparam int unsigned DEPTH      = depth(DEPTH_MAG);
  localparam int unsigned CTX_W      = ctx_width(CONTEXTS);

  typedef struct packed {
    slot_state_t           state;
    logic [WORD_WIDTH-1:0] data;
  } slot_t;

  logic [CONTEXTS-1:0][DEPTH_MAG-1:0]               ctx_head;
  logic [CONTEXTS-1:0][DEPTH-1:0][1:0]              ctx_states;
  logic [CONTEXTS-1:0][DEPTH-1:0][WORD_WIDTH-1:0]   ctx_data;
  logic [CONTEXTS-1:0][DEPTH_MAG:0]                 ctx_occ;
  logic [CONTEXTS-1:0]                              ctx_alloc;
  logic [CONTEXTS-1:0]                              ctx_consume;
  logic [CONTEXTS-1:0]                              ctx_consume_fwd;
  logic [CONTEXTS-1:0]                              ctx_err;
  logic [CONTEXTS-1:0][WRITE_PORTS-1:0]             ctx_wr_en;
  logic [DEPTH_MAG-1:0]                             alloc_slot;
  logic [DEPTH_MAG-1:0]                             rd_slot;
  logic                                             alloc_ready;
  logic                                             fwd_hit;
  logic                                             error_q;
  slot_t                                            rd_entry;

  assign alloc_slot  = ctx_head[bus.alloc_ctx] - DEPTH_MAG'(1);
  assign alloc_ready = (ctx_states[bus.alloc_ctx][alloc_slot] == FREE);

  assign rd_slot  = ctx_head[bus.rd_ctx] + bus.rd_offset;
  assign rd_entry = '{state: slot_state_t'(ctx_states[bus.rd_ctx][rd_slot]),
                      data:  ctx_data[bus.rd_ctx][rd_slot]};

`ifdef CONVEYOR_FORWARD_EN
  logic [WORD_WIDTH-1:0] fwd_data;

  // Descending scan so the lowest-index matching port is the one forwarded.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int p = WRITE_PORTS - 1; p >= 0; p--) begin
      if (bus.wr_valid[p] && bus.wr_ctx[p] == bus.rd_ctx && bus.wr_slot[p] == rd_slot &&
          rd_entry.state == PENDING && !bus.flush[bus.rd_ctx]) begin
        fwd_hit  = 1'b1;
        fwd_data = bus.wr_data[p];
      end
    end
  end

  assign bus.rd_data     = fwd_hit ? fwd_data : rd_entry.data;
  assign bus.rd_finished = fwd_hit || (rd_entry.state == DONE);
`else
  assign fwd_hit         = 1'b0;
  assign bus.rd_data     = rd_entry.data;
  assign bus.rd_finished = (rd_entry.state == DONE);
`endif

  for (genvar c = 0; c < CONTEXTS; c++) begin : g_ctx
    assign ctx_alloc[c]       = bus.alloc && alloc_ready && (bus.alloc_ctx == CTX_W'(c));
    assign ctx_consume[c]     = bus.rd_consume && (bus.rd_ctx == CTX_W'(c));
    assign ctx_consume_fwd[c] = ctx_consume[c] && fwd_hit;

    for (genvar p = 0; p < WRITE_PORTS; p++) begin : g_port
      assign ctx_wr_en[c][p] = bus.wr_valid[p] && (bus.wr_ctx[p] == CTX_W'(c));
    end

    conveyor_context #(
      .WORD_WIDTH  (WORD_WIDTH),
      .DEPTH_MAG   (DEPTH_MAG),
      .WRITE_PORTS (WRITE_PORTS)
    ) u_ctx (
      .clk          (clk),
      .reset        (reset),
      .flush        (bus.flush[c]),
      .alloc        (ctx_alloc[c]),
      .wr_en        (ctx_wr_en[c]),
      .wr_slot      (bus.wr_slot),
      .wr_data      (bus.wr_data),
      .consume      (ctx_consume[c]),
      .consume_fwd  (ctx_consume_fwd[c]),
      .consume_slot (rd_slot),
      .head         (ctx_head[c]),
      .states       (ctx_states[c]),
      .data         (ctx_data[c]),
      .occupancy    (ctx_occ[c]),
      .err          (ctx_err[c])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      error_q <= 1'b0;
    end else if (|ctx_err) begin
      error_q <= 1'b1;
    end
  end

  assign bus.alloc_ready = alloc_ready;
  assign bus.alloc_slot  = alloc_slot;
  assign bus.occupancy   = ctx_occ;
  assign bus.error       = error_q;

endmodule

// File: tb/tb_conveyor_file.sv
// Self-checking bench for conveyor_file: vector table, write scoreboard, corner sequences.
module tb_conveyor_file;
  localparam int unsigned WORD_MAG    = 5;
  localparam int unsigned DEPTH_MAG   = 4;
  localparam int unsigned CONTEXTS    = 2;
  localparam int unsigned WRITE_PORTS = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conveyor_if #(
    .WORD_MAG    (WORD_MAG),
    .DEPTH_MAG   (DEPTH_MAG),
    .CONTEXTS    (CONTEXTS),
    .WRITE_PORTS (WRITE_PORTS)
  ) bus ();

  conveyor_file #(
    .WORD_MAG    (WORD_MAG),
    .DEPTH_MAG   (DEPTH_MAG),
    .CONTEXTS    (CONTEXTS),
    .WRITE_PORTS (WRITE_PORTS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        alloc;
    logic        wr;
    logic [3:0]  wslot;
    logic [31:0] wdata;
    logic [3:0]  roff;
    logic        cons;
    logic        e_ready;
    logic [3:0]  e_slot;
    logic        e_fin;
    logic [31:0] e_data;
    logic [4:0]  e_occ0;
    logic        e_err;
  } vec_t;

  typedef struct {
    logic [3:0]  slot;
    logic [31:0] data;
  } sb_t;

  vec_t vecs[9];
  sb_t  sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alloc      = 1'b0;
    bus.alloc_ctx  = '0;
    bus.wr_valid   = '0;
    bus.wr_ctx     = '0;
    bus.wr_slot    = '0;
    bus.wr_data    = '0;
    bus.rd_ctx     = '0;
    bus.rd_offset  = '0;
    bus.rd_consume = 1'b0;
    bus.flush      = '0;
  endtask

  task automatic wr(input int p, input logic c, input logic [3:0] s, input logic [31:0] d);
    bus.wr_valid[p] = 1'b1;
    bus.wr_ctx[p]   = c;
    bus.wr_slot[p]  = s;
    bus.wr_data[p]  = d;
  endtask

  task automatic rd(input logic c, input logic [3:0] off, input logic cons);
    bus.rd_ctx     = c;
    bus.rd_offset  = off;
    bus.rd_consume = cons;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sb_t         e;
    logic [31:0] d0, d1;

    // alloc wr wslot wdata roff cons | ready slot fin data occ0 err
    vecs[0] = '{1'b1, 1'b0, 4'd0,  32'h0,        4'd0, 1'b0, 1'b1, 4'd15, 1'b0, 32'h0,        5'd0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 4'd0,  32'h0,        4'd0, 1'b0, 1'b1, 4'd14, 1'b0, 32'h0,        5'd1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 4'd0,  32'h0,        4'd0, 1'b0, 1'b1, 4'd13, 1'b0, 32'h0,        5'd2, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 4'd0,  32'h0,        4'd0, 1'b0, 1'b1, 4'd12, 1'b0, 32'h0,        5'd3, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 4'd14, 32'hDEADBEEF, 4'd2, 1'b0, 1'b1, 4'd12, 1'b0, 32'h0,        5'd3, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 4'd0,  32'h0,        4'd1, 1'b1, 1'b1, 4'd12, 1'b1, 32'hDEADBEEF, 5'd3, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 4'd0,  32'h0,        4'd0, 1'b0, 1'b1, 4'd12, 1'b0, 32'h0,        5'd2, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 4'd0,  32'h0,        4'd2, 1'b0, 1'b1, 4'd12, 1'b0, 32'h0,        5'd2, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 4'd0,  32'h0,        4'd0, 1'b0, 1'b1, 4'd11, 1'b0, 32'h0,        5'd3, 1'b0};

    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #2;
    check("rst_alloc_ready", 32'(bus.alloc_ready), 32'd1);
    check("rst_alloc_slot", 32'(bus.alloc_slot), 32'd15);
    check("rst_rd_finished", 32'(bus.rd_finished), 32'd0);
    check("rst_rd_data", bus.rd_data, 32'd0);
    check("rst_occ0", 32'(bus.occupancy[0]), 32'd0);
    check("rst_occ1", 32'(bus.occupancy[1]), 32'd0);
    check("rst_error", 32'(bus.error), 32'd0);

    // Context 0 allocation, write, read-back and consume.
    for (int i = 0; i < 9; i++) begin
      idle();
      bus.alloc = vecs[i].alloc;
      if (vecs[i].wr) wr(0, 1'b0, vecs[i].wslot, vecs[i].wdata);
      rd(1'b0, vecs[i].roff, vecs[i].cons);
      #2;
      check($sformatf("v%0d_alloc_ready", i), 32'(bus.alloc_ready), 32'(vecs[i].e_ready));
      check($sformatf("v%0d_alloc_slot", i), 32'(bus.alloc_slot), 32'(vecs[i].e_slot));
      check($sformatf("v%0d_rd_finished", i), 32'(bus.rd_finished), 32'(vecs[i].e_fin));
      check($sformatf("v%0d_rd_data", i), bus.rd_data, vecs[i].e_data);
      check($sformatf("v%0d_occ0", i), 32'(bus.occupancy[0]), 32'(vecs[i].e_occ0));
      check($sformatf("v%0d_error", i), 32'(bus.error), 32'(vecs[i].e_err));
      tick();
    end

    // Fill context 1 completely; the next alloc must be refused.
    for (int i = 0; i < 16; i++) begin
      idle();
      bus.alloc     = 1'b1;
      bus.alloc_ctx = 1'b1;
      #2;
      check("fill_alloc_ready", 32'(bus.alloc_ready), 32'd1);
      check("fill_alloc_slot", 32'(bus.alloc_slot), 32'((15 - i) & 15));
      tick();
    end
    idle();
    bus.alloc     = 1'b1;
    bus.alloc_ctx = 1'b1;
    #2;
    check("full_alloc_ready", 32'(bus.alloc_ready), 32'd0);
    check("full_occ1", 32'(bus.occupancy[1]), 32'd16);
    tick();
    idle();
    bus.alloc_ctx = 1'b1;
    #2;
    check("full_ignored_occ1", 32'(bus.occupancy[1]), 32'd16);
    check("full_ignored_slot", 32'(bus.alloc_slot), 32'd15);
    check("ctx0_untouched_occ", 32'(bus.occupancy[0]), 32'd3);

    d0 = $urandom;
    wr(1, 1'b1, 4'd15, d0);
    sb.push_back('{slot: 4'd15, data: d0});
    tick();
    idle();
    e = sb.pop_front();
    rd(1'b1, e.slot, 1'b1);
    bus.alloc_ctx = 1'b1;
    #2;
    check("s15_rd_finished", 32'(bus.rd_finished), 32'd1);
    check("s15_rd_data", bus.rd_data, e.data);
    check("s15_ready_same_cycle", 32'(bus.alloc_ready), 32'd0);
    tick();
    idle();
    bus.alloc_ctx = 1'b1;
    #2;
    check("s15_ready_next_cycle", 32'(bus.alloc_ready), 32'd1);
    check("s15_occ1", 32'(bus.occupancy[1]), 32'd15);

    for (int s = 0; s < 15; s += 2) begin
      idle();
      d0 = $urandom;
      wr(0, 1'b1, 4'(s), d0);
      sb.push_back('{slot: 4'(s), data: d0});
      if (s + 1 < 15) begin
        d1 = $urandom;
        wr(1, 1'b1, 4'(s + 1), d1);
        sb.push_back('{slot: 4'(s + 1), data: d1});
      end
      tick();
    end
    while (sb.size() > 0) begin
      idle();
      e = sb.pop_front();
      rd(1'b1, e.slot, 1'b1);
      #2;
      check($sformatf("sb_fin_s%0d", e.slot), 32'(bus.rd_finished), 32'd1);
      check($sformatf("sb_data_s%0d", e.slot), bus.rd_data, e.data);
      tick();
    end
    idle();
    #2;
    check("drain_occ1", 32'(bus.occupancy[1]), 32'd0);
    check("drain_error", 32'(bus.error), 32'd0);

    // Flush context 0 while a write targets one of its pending slots.
    idle();
    bus.flush = 2'b01;
    wr(0, 1'b0, 4'd13, 32'h77);
    tick();
    idle();
    rd(1'b0, 4'd13, 1'b0);
    #2;
    check("flush_occ0", 32'(bus.occupancy[0]), 32'd0);
    check("flush_head_slot", 32'(bus.alloc_slot), 32'd15);
    check("flush_rd_finished", 32'(bus.rd_finished), 32'd0);
    wr(0, 1'b0, 4'd13, 32'h99);
    tick();
    idle();
    rd(1'b0, 4'd13, 1'b0);
    #2;
    check("late_wr_finished", 32'(bus.rd_finished), 32'd0);
    check("late_wr_error", 32'(bus.error), 32'd0);
    check("late_wr_occ0", 32'(bus.occupancy[0]), 32'd0);

    // Write and consume the same slot in one cycle.
    idle();
    bus.alloc = 1'b1;
    tick();
    idle();
    wr(0, 1'b0, 4'd15, 32'h55);
    rd(1'b0, 4'd0, 1'b1);
    #2;
`ifdef CONVEYOR_FORWARD_EN
    check("fwd_rd_finished", 32'(bus.rd_finished), 32'd1);
    check("fwd_rd_data", bus.rd_data, 32'h55);
`else
    check("nofwd_rd_finished", 32'(bus.rd_finished), 32'd0);
`endif
    tick();
    idle();
    #2;
`ifdef CONVEYOR_FORWARD_EN
    check("fwd_slot_free", 32'(bus.rd_finished), 32'd0);
    check("fwd_occ0", 32'(bus.occupancy[0]), 32'd0);
    check("fwd_error", 32'(bus.error), 32'd0);
`else
    check("nofwd_slot_done", 32'(bus.rd_finished), 32'd1);
    check("nofwd_rd_data", bus.rd_data, 32'h55);
    check("nofwd_occ0", 32'(bus.occupancy[0]), 32'd1);
    check("nofwd_error", 32'(bus.error), 32'd1);
`endif

    // Reset mid-operation, then a late write, then a port collision.
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd(1'b0, 4'd15, 1'b0);
    #2;
    check("rst2_error", 32'(bus.error), 32'd0);
    check("rst2_occ0", 32'(bus.occupancy[0]), 32'd0);
    check("rst2_alloc_slot", 32'(bus.alloc_slot), 32'd15);
    check("rst2_rd_data", bus.rd_data, 32'd0);
    wr(0, 1'b0, 4'd15, 32'hAA);
    tick();
    idle();
    rd(1'b0, 4'd15, 1'b0);
    #2;
    check("post_rst_wr_finished", 32'(bus.rd_finished), 32'd0);
    check("post_rst_wr_error", 32'(bus.error), 32'd0);
    for (int i = 0; i < 3; i++) begin
      idle();
      bus.alloc = 1'b1;
      tick();
    end
    idle();
    wr(0, 1'b0, 4'd13, 32'h1);
    wr(1, 1'b0, 4'd13, 32'h2);
    tick();
    idle();
    rd(1'b0, 4'd0, 1'b0);
    #2;
    check("coll_rd_data", bus.rd_data, 32'h1);
    check("coll_rd_finished", 32'(bus.rd_finished), 32'd1);
    check("coll_error", 32'(bus.error), 32'd1);
    check("coll_occ0", 32'(bus.occupancy[0]), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
